// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO result stage: request encodings, FSM states
// and the default register width.
package hilo_unit_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_MUL  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_DIV_WAIT = 2'b01,
    S_MUL_WAIT = 2'b10
  } state_e;

endpackage

// File: rtl/hilo_unit_settle_counter.sv
// Down-counter that times the settle window of the divider/multiplier paths.
// load takes priority over dec; the count stops at zero.
module hilo_unit_settle_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/hilo_unit.sv
// HI/LO result stage: latches operands for the external divider/multiplier,
// waits a fixed settle window, then captures the results into HI/LO.
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DIV_CYCLES = 4,
  parameter int MUL_CYCLES = 2
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [DATA_W-1:0]   src_a,
  input  logic [DATA_W-1:0]   src_b,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic                div_by_zero,
  output logic [DATA_W-1:0]   op_a,
  output logic [DATA_W-1:0]   op_b,
  input  logic [DATA_W-1:0]   div_quotient,
  input  logic [DATA_W-1:0]   div_remainder,
  input  logic [2*DATA_W-1:0] mul_product,
  input  logic                rd_sel,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic [1:0]          dbg_state
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  // Handshake: a request is taken on a rising edge with start=1 and ready=1;
  // done is high for the single cycle after HI/LO change; reads are valid
  // whenever busy=0.

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic                done_q, done_d;
  logic                dbz_q, dbz_d;

  logic                cnt_load;
  logic [CNT_W-1:0]    cnt_load_val;
  logic                cnt_dec;
  logic                cnt_zero;

  hilo_unit_settle_counter #(
    .CNT_W (CNT_W)
  ) u_settle (
    .clk      (clock),
    .rst_n    (clear),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    done_d       = 1'b0;
    dbz_d        = dbz_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dbz_d = 1'b0;
          case (op_e'(op))
            OP_DIV: begin
              op_a_d       = src_a;
              op_b_d       = src_b;
              cnt_load     = 1'b1;
              cnt_load_val = DIV_LOAD;
              dbz_d        = (src_b == '0);
              state_d      = S_DIV_WAIT;
            end
            OP_MUL: begin
              op_a_d       = src_a;
              op_b_d       = src_b;
              cnt_load     = 1'b1;
              cnt_load_val = MUL_LOAD;
              state_d      = S_MUL_WAIT;
            end
            OP_MTHI: begin
              hi_d   = src_a;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = src_a;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_DIV_WAIT: begin
        // Divider output is taken verbatim, including its divide-by-zero value.
        if (cnt_zero) begin
          lo_d    = div_quotient;
          hi_d    = div_remainder;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_MUL_WAIT: begin
        if (cnt_zero) begin
          hi_d    = mul_product[2*DATA_W-1:DATA_W];
          lo_d    = mul_product[DATA_W-1:0];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign ready       = (state_q == S_IDLE);
  assign busy        = (state_q == S_DIV_WAIT) || (state_q == S_MUL_WAIT);
  assign rd_valid    = !busy;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign rd_data     = rd_sel ? hi_q : lo_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed scenarios plus randomized
// requests checked against an arithmetic HI/LO model.
module tb_hilo_unit;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  logic        clock;
  logic        clear;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        ready, busy, done, div_by_zero;
  logic [31:0] op_a, op_b;
  logic [31:0] div_quotient, div_remainder;
  logic [63:0] mul_product;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [1:0]  dbg_state;

  int total;
  int passed;
  logic [63:0] exp_q[$];

  hilo_unit #(
    .DATA_W     (32),
    .DIV_CYCLES (4),
    .MUL_CYCLES (2)
  ) dut (
    .clock         (clock),
    .clear         (clear),
    .start         (start),
    .op            (op),
    .src_a         (src_a),
    .src_b         (src_b),
    .ready         (ready),
    .busy          (busy),
    .done          (done),
    .div_by_zero   (div_by_zero),
    .op_a          (op_a),
    .op_b          (op_b),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .mul_product   (mul_product),
    .rd_sel        (rd_sel),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog");
  end

  // Stand-in combinational divider and multiplier fed from the latched operands.
  always_comb begin
    if (op_b == 32'd0) begin
      div_quotient  = 32'hFFFF_FFFF;
      div_remainder = 32'hFFFF_FFFF;
    end else if (op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF) begin
      div_quotient  = 32'h7FFF_FFFF;
      div_remainder = 32'd0;
    end else begin
      div_quotient  = $signed(op_a) / $signed(op_b);
      div_remainder = $signed(op_a) % $signed(op_b);
    end
  end
  assign mul_product = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});

  // ---------------- reference model ----------------
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    longint la, lb, q, r, p;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    case (o)
      OP_DIV: begin
        if (b == 32'd0) return {32'hFFFF_FFFF, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h7FFF_FFFF};
        q = la / lb;
        r = la - q * lb;
        return {r[31:0], q[31:0]};
      end
      OP_MUL: begin
        p = la * lb;
        return p;
      end
      OP_MTHI: return {a, cur[31:0]};
      default: return {cur[63:32], a};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic rd(input logic s, output logic [31:0] d);
    rd_sel = s;
    #1;
    d = rd_data;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    total++;
    if (ready !== 1'b1) $display("FAIL issue_ready: ready=%b required 1", ready);
    else passed++;
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    @(negedge clock);
    start = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
  endtask

  // Counts busy cycles from the current negedge until busy falls.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      total++;
      if (rd_valid !== 1'b0) $display("FAIL rd_valid_busy: rd_valid=%b required 0", rd_valid);
      else passed++;
      n++;
      @(negedge clock);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] v;
    total++;
    if ({ready, busy, done, div_by_zero, rd_valid} !== 5'b10001)
      $display("FAIL reset_flags: rdy/busy/done/dbz/rdv=%b required 10001",
               {ready, busy, done, div_by_zero, rd_valid});
    else passed++;
    total++;
    if ({op_a, op_b} !== 64'd0) $display("FAIL reset_ops: op_a=%h op_b=%h required 0", op_a, op_b);
    else passed++;
    rd(1'b1, v);
    total++;
    if (v !== 32'd0) $display("FAIL reset_hi: hi=%h required 0", v);
    else passed++;
    clear = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_div_basic();
    int n;
    logic [31:0] v;
    issue(OP_DIV, 32'd100, 32'd7);
    total++;
    if (op_a !== 32'd100 || op_b !== 32'd7) $display("FAIL div_latch: op_a=%0d op_b=%0d required 100 7", op_a, op_b);
    else passed++;
    wait_idle(n);
    total++;
    if (n !== 4) $display("FAIL div_busy_cycles: got %0d required 4", n);
    else passed++;
    total++;
    if (done !== 1'b1) $display("FAIL div_done: done=%b required 1", done);
    else passed++;
    rd(1'b0, v);
    total++;
    if (v !== 32'd14) $display("FAIL div_lo: lo=%0d required 14", v);
    else passed++;
    rd(1'b1, v);
    total++;
    if (v !== 32'd2) $display("FAIL div_hi: hi=%0d required 2", v);
    else passed++;
    total++;
    if (div_by_zero !== 1'b0) $display("FAIL div_dbz: dbz=%b required 0", div_by_zero);
    else passed++;
    @(negedge clock);
    total++;
    if (done !== 1'b0) $display("FAIL div_done_pulse: done=%b required 0", done);
    else passed++;
  endtask

  task automatic test_div_signed();
    int n;
    logic [31:0] v;
    issue(OP_DIV, -32'sd100, 32'd7);
    wait_idle(n);
    rd(1'b0, v);
    total++;
    if (v !== 32'hFFFF_FFF2) $display("FAIL sdiv_lo: lo=%h required fffffff2", v);
    else passed++;
    rd(1'b1, v);
    total++;
    if (v !== 32'hFFFF_FFFE) $display("FAIL sdiv_hi: hi=%h required fffffffe", v);
    else passed++;
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    rd(1'b0, v);
    total++;
    if (v !== 32'h7FFF_FFFF) $display("FAIL sat_lo: lo=%h required 7fffffff", v);
    else passed++;
    rd(1'b1, v);
    total++;
    if (v !== 32'd0) $display("FAIL sat_hi: hi=%h required 0", v);
    else passed++;
  endtask

  task automatic test_div_zero();
    int n;
    logic [31:0] v;
    issue(OP_DIV, 32'd55, 32'd0);
    wait_idle(n);
    total++;
    if (div_by_zero !== 1'b1) $display("FAIL dbz_set: dbz=%b required 1", div_by_zero);
    else passed++;
    rd(1'b0, v);
    total++;
    if (v !== 32'hFFFF_FFFF) $display("FAIL dbz_lo: lo=%h required ffffffff", v);
    else passed++;
    rd(1'b1, v);
    total++;
    if (v !== 32'hFFFF_FFFF) $display("FAIL dbz_hi: hi=%h required ffffffff", v);
    else passed++;
    @(negedge clock);
    total++;
    if (div_by_zero !== 1'b1) $display("FAIL dbz_sticky: dbz=%b required 1", div_by_zero);
    else passed++;
    issue(OP_MTLO, 32'h12, 32'd0);
    total++;
    if (div_by_zero !== 1'b0 || done !== 1'b1 || busy !== 1'b0)
      $display("FAIL mtlo_flags: dbz=%b done=%b busy=%b required 0 1 0", div_by_zero, done, busy);
    else passed++;
    rd(1'b0, v);
    total++;
    if (v !== 32'h12) $display("FAIL mtlo_lo: lo=%h required 12", v);
    else passed++;
  endtask

  task automatic test_mul_ignore();
    int n;
    logic [31:0] v;
    issue(OP_MUL, -32'sd3, 32'd5);
    start = 1'b1;
    op    = OP_DIV;
    src_a = 32'd1;
    src_b = 32'd0;
    @(negedge clock);
    start = 1'b0;
    total++;
    if (op_a !== 32'hFFFF_FFFD || op_b !== 32'd5)
      $display("FAIL mul_hold_ops: op_a=%h op_b=%h required fffffffd 00000005", op_a, op_b);
    else passed++;
    wait_idle(n);
    total++;
    if (n !== 1) $display("FAIL mul_busy_cycles: got %0d required 2", n + 1);
    else passed++;
    rd(1'b1, v);
    total++;
    if (v !== 32'hFFFF_FFFF) $display("FAIL mul_hi: hi=%h required ffffffff", v);
    else passed++;
    rd(1'b0, v);
    total++;
    if (v !== 32'hFFFF_FFF1) $display("FAIL mul_lo: lo=%h required fffffff1", v);
    else passed++;
    total++;
    if (div_by_zero !== 1'b0 || ready !== 1'b1)
      $display("FAIL mul_ignored_start: dbz=%b ready=%b required 0 1", div_by_zero, ready);
    else passed++;
  endtask

  task automatic test_abort();
    logic [31:0] v;
    int seen_done;
    issue(OP_DIV, 32'd100, 32'd7);
    @(negedge clock);
    #2 clear = 1'b0;
    #1;
    total++;
    if ({busy, ready, rd_valid, done} !== 4'b0110)
      $display("FAIL abort_flags: busy/ready/rdv/done=%b required 0110", {busy, ready, rd_valid, done});
    else passed++;
    rd(1'b0, v);
    total++;
    if (v !== 32'd0) $display("FAIL abort_lo: lo=%h required 0", v);
    else passed++;
    rd(1'b1, v);
    total++;
    if (v !== 32'd0 || op_a !== 32'd0) $display("FAIL abort_hi: hi=%h op_a=%h required 0 0", v, op_a);
    else passed++;
    @(negedge clock);
    clear = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    total++;
    if (seen_done !== 0) $display("FAIL abort_no_done: active cycles=%0d required 0", seen_done);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] v;
    issue(OP_MTHI, 32'h0000_ABCD, 32'd0);
    issue(OP_DIV, 32'd9, 32'd2);
    rd(1'b1, v);
    total++;
    if (rd_valid !== 1'b0 || v !== 32'h0000_ABCD)
      $display("FAIL b2b_read_busy: rd_valid=%b hi=%h required 0 0000abcd", rd_valid, v);
    else passed++;
    wait_idle(n);
    total++;
    if (n !== 4 || done !== 1'b1) $display("FAIL b2b_div: cycles=%0d done=%b required 4 1", n, done);
    else passed++;
    rd(1'b0, v);
    total++;
    if (v !== 32'd4) $display("FAIL b2b_div_lo: lo=%0d required 4", v);
    else passed++;
    issue(OP_MUL, 32'd4, 32'd4);
    total++;
    if (busy !== 1'b1 || op_a !== 32'd4) $display("FAIL b2b_accept: busy=%b op_a=%h required 1 4", busy, op_a);
    else passed++;
    wait_idle(n);
    total++;
    if (n !== 2) $display("FAIL b2b_mul_cycles: got %0d required 2", n);
    else passed++;
    rd(1'b1, v);
    total++;
    if (v !== 32'd0) $display("FAIL b2b_hi: hi=%h required 0", v);
    else passed++;
    rd(1'b0, v);
    total++;
    if (v !== 32'd16) $display("FAIL b2b_lo: lo=%0d required 16", v);
    else passed++;
  endtask

  task automatic test_random();
    logic [63:0] cur, exp_v;
    logic [31:0] a, b, hi, lo;
    logic [1:0]  o;
    logic        exp_dbz;
    int n, exp_n;
    cur = {32'd0, 32'd16};
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      exp_v = model(o, a, b, cur);
      exp_q.push_back(exp_v);
      exp_dbz = (o == OP_DIV) && (b == 32'd0);
      exp_n = (o == OP_DIV) ? 4 : (o == OP_MUL) ? 2 : 0;
      issue(o, a, b);
      wait_idle(n);
      total++;
      if (n !== exp_n || done !== 1'b1)
        $display("FAIL rnd_timing[%0d]: op=%0d cycles=%0d done=%b required %0d 1", i, o, n, done, exp_n);
      else passed++;
      exp_v = exp_q.pop_front();
      rd(1'b1, hi);
      rd(1'b0, lo);
      total++;
      if ({hi, lo} !== exp_v)
        $display("FAIL rnd_hilo[%0d]: op=%0d a=%h b=%h got %h_%h required %h", i, o, a, b, hi, lo, exp_v);
      else passed++;
      total++;
      if (div_by_zero !== exp_dbz) $display("FAIL rnd_dbz[%0d]: dbz=%b required %b", i, div_by_zero, exp_dbz);
      else passed++;
      cur = exp_v;
      if ($urandom_range(0, 1) == 1) @(negedge clock);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total  = 0;
    passed = 0;
    clear  = 1'b0;
    start  = 1'b0;
    op     = 2'b00;
    src_a  = 32'd0;
    src_b  = 32'd0;
    rd_sel = 1'b0;
    repeat (2) @(negedge clock);
    test_reset();
    test_div_basic();
    test_div_signed();
    test_div_zero();
    test_mul_ignore();
    test_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Sequential HI/LO result stage directly downstream of the combinational 32-bit signed divider. Also fed by the 32x32 multiplier.
- Accepts a DIV/MUL/MTHI/MTLO request from the control unit. Latches the operands and drives them, held stable, into the divider/multiplier.
- Waits a parameterised multicycle settle count, then captures quotient→LO and remainder→HI (or product[63:32]→HI, product[31:0]→LO).
- Serves MFHI/MFLO reads, and exposes busy/done handshakes plus a divide-by-zero flag.

Parameters:
- DATA_W, 32, operand/register width.
- DIV_CYCLES, 4, settle cycles allowed for the combinational divider path (≥1).
- MUL_CYCLES, 2, settle cycles allowed for the multiplier path (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; accepted only when ready=1.
- op  in  2  00 DIV, 01 MUL, 10 MTHI, 11 MTLO.
- src_a  in  DATA_W  dividend / multiplicand / MTHI-MTLO data.
- src_b  in  DATA_W  divisor / multiplier.
- ready  out  1  high in IDLE only.
- busy  out  1  high while in DIV_WAIT or MUL_WAIT.
- done  out  1  one-cycle pulse when HI/LO have been updated.
- div_by_zero  out  1  sticky flag; set when an accepted DIV has src_b==0; cleared on the next accepted start.
- op_a  out  DATA_W  latched operand A to divider/multiplier.
- op_b  out  DATA_W  latched operand B.
- div_quotient  in  DATA_W  from divider.
- div_remainder  in  DATA_W  from divider.
- mul_product  in  2*DATA_W  from multiplier.
- rd_sel  in  1  0=LO, 1=HI.
- rd_data  out  DATA_W  combinational read of the selected register.
- rd_valid  out  1  equals !busy; MFHI/MFLO must stall while low.

Behaviour:
- Reset (clear=0, asynchronous):
  - State=IDLE; HI=LO=0; op_a=op_b=0; count=0.
  - done=0, busy=0, div_by_zero=0, ready=1.
  - Reset asserted mid-operation aborts the operation; HI/LO are not updated.
- States: IDLE, DIV_WAIT, MUL_WAIT.
- IDLE, start=1 (edge E0):
  - DIV: op_a←src_a, op_b←src_b, count←DIV_CYCLES-1, state→DIV_WAIT, div_by_zero←(src_b==0).
  - MUL: same operand latch, count←MUL_CYCLES-1, state→MUL_WAIT, div_by_zero←0.
  - MTHI: HI←src_a at E0, done=1 next cycle, stay IDLE, div_by_zero←0.
  - MTLO: as MTHI but writes LO.
- WAIT states:
  - count decrements each edge while count≠0.
  - On the edge where count==0:
    - DIV: LO←div_quotient, HI←div_remainder.
    - MUL: HI←mul_product[63:32], LO←mul_product[31:0].
    - state→IDLE; done=1 for exactly the following cycle.
- Latency:
  - HI/LO are updated at edge E0+DIV_CYCLES (DIV) or E0+MUL_CYCLES (MUL).
  - busy is high for exactly DIV_CYCLES / MUL_CYCLES cycles.
- op_a/op_b are held constant from E0 until the next accepted start, never changing mid-wait. The captured value is taken verbatim from the divider, including its divisor-0 result (all-ones) and its most-negative ÷ -1 saturation (0x7FFFFFFF, remainder 0).
- start while ready=0 is ignored; there is no queuing and no error.
- start on the same cycle done=1 is legal and is accepted (state is already IDLE).
- A simultaneous read during the capture edge returns the old value; rd_valid is still 0 in that cycle.
- rd_data is combinational from HI/LO and is valid whenever rd_valid=1.
- No arithmetic is performed in this block; it handles width routing only.

Decomposition:
- Shared package holds:
  - op encodings (OP_DIV, OP_MUL, OP_MTHI, OP_MTLO);
  - state enum (S_IDLE, S_DIV_WAIT, S_MUL_WAIT);
  - DATA_W default.
- One natural sub-module: settle_counter (load value, decrement, zero flag). It is reused for both wait states; the FSM and HI/LO registers stay in the top.

Test Plan:
- DIV, src_a=100, src_b=7, DIV_CYCLES=4, real divider instanced → busy high 4 cycles; after the 4th edge LO=14, HI=2; done one cycle; div_by_zero=0.
- DIV, -100 ÷ 7 → LO=0xFFFFFFF2 (-14), HI=0xFFFFFFFE (-2). Then 0x80000000 ÷ 0xFFFFFFFF → LO=0x7FFFFFFF, HI=0.
- DIV, 55 ÷ 0 → div_by_zero=1, HI=LO=0xFFFFFFFF. A following MTLO 0x12 → div_by_zero=0, LO=0x12 one cycle later, done pulsed.
- MUL, -3 × 5, MUL_CYCLES=2 → HI=0xFFFFFFFF, LO=0xFFFFFFF1 after 2 edges. A start issued during busy is ignored, with op_a/op_b unchanged.
- DIV 100÷7 accepted, clear pulsed low after 2 cycles → immediately HI=LO=0, busy=0, ready=1; no done pulse; rd_valid=1 with rd_data=0.
- Back-to-back: DIV 9÷2 completes, start MUL 4×4 asserted in the done cycle → accepted; final HI=0, LO=16; an earlier read of HI during busy shows rd_valid=0.
